photo_capture: RTL and testbench

Captures one filtered frame window into the passport photo frame buffer. Sits directly downstream of the filter stage. It consumes the 24-bit filtered pixel stream plus raster coordinates, and on a capture request it waits for the next frame start. It then writes every pixel inside a fixed rectangular window, packed to 12-bit 4:4:4, into a BRAM write port in raster order, and reports completion.

---
 rtl/photo_capture.sv | 184 ++++++++++++++++++
 tb/tb_photo_capture.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/photo_capture.sv
// photo_capture: grabs one window of the filtered raster into the
// passport frame buffer as 12-bit 4:4:4 writes, one capture per request.
module photo_capture #(
  parameter int PIPE_DLY = 1,
  parameter int WIN_X    = 192,
  parameter int WIN_Y    = 112,
  parameter int WIN_W    = 256,
  parameter int WIN_H    = 256,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic              abort,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  input  logic [23:0]       rgb_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic              busy,
  output logic              done
);

  localparam int TOTAL = WIN_W * WIN_H;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TOTAL - 1);
  localparam logic [10:0] X_LO = 11'(WIN_X);
  localparam logic [10:0] X_HI = 11'(WIN_X + WIN_W - 1);
  localparam logic [9:0]  Y_LO = 10'(WIN_Y);
  localparam logic [9:0]  Y_HI = 10'(WIN_Y + WIN_H - 1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    CAPTURE,
    DONE
  } state_t;

  logic [10:0] hd;
  logic [9:0]  vd;

  generate
    if (PIPE_DLY == 0) begin : g_nodly
      assign hd = hcount;
      assign vd = vcount;
    end else begin : g_dly
      logic [10:0] hpipe_q [PIPE_DLY];
      logic [10:0] hpipe_d [PIPE_DLY];
      logic [9:0]  vpipe_q [PIPE_DLY];
      logic [9:0]  vpipe_d [PIPE_DLY];

      always_comb begin
        hpipe_d[0] = hcount;
        vpipe_d[0] = vcount;
        for (int i = 1; i < PIPE_DLY; i++) begin
          hpipe_d[i] = hpipe_q[i-1];
          vpipe_d[i] = vpipe_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < PIPE_DLY; i++) begin
            hpipe_q[i] <= '0;
            vpipe_q[i] <= '0;
          end
        end else begin
          hpipe_q <= hpipe_d;
          vpipe_q <= vpipe_d;
        end
      end

      assign hd = hpipe_q[PIPE_DLY-1];
      assign vd = vpipe_q[PIPE_DLY-1];
    end
  endgenerate

  logic        frame_start;
  logic        in_win;
  logic [11:0] pix_pack;
  logic        unused_lsbs;

  assign frame_start = (hd == '0) && (vd == '0);
  assign in_win = (hd >= X_LO) && (hd <= X_HI) &&
                  (vd >= Y_LO) && (vd <= Y_HI);
  assign pix_pack = {rgb_in[23:20], rgb_in[15:12], rgb_in[7:4]};
  assign unused_lsbs = ^{rgb_in[19:16], rgb_in[11:8], rgb_in[3:0]};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [11:0]       wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              take;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    take      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = ARM;
          busy_d  = 1'b1;
        end
      end
      ARM: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (frame_start) begin
          state_d = CAPTURE;
          // a window touching (0,0) must not lose its first pixel
          take    = in_win;
        end
      end
      CAPTURE: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          take = in_win;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
    if (take) begin
      wr_en_d   = 1'b1;
      wr_addr_d = cnt_q;
      wr_data_d = pix_pack;
      cnt_d     = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        state_d = DONE;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_photo_capture.sv
// tb_photo_capture: directed bench for photo_capture on an 8x4 raster,
// one instance with a 1-cycle pixel pipe and one with none.
module tb_photo_capture;

  localparam int WX = 2;
  localparam int WY = 1;
  localparam int WW = 4;
  localparam int WH = 2;
  localparam int AW = 4;
  localparam int NPIX = WW * WH;
  localparam int HT = 8;
  localparam int VT = 4;
  localparam int FR = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cap1 = 1'b0, abt1 = 1'b0;
  logic cap0 = 1'b0, abt0 = 1'b0;
  logic [10:0] h = '0;
  logic [9:0]  v = '0;
  logic [10:0] ph = '0;
  logic [9:0]  pv = '0;
  int r = 0;
  int pat = 0;
  logic [23:0] rgb1, rgb0;

  logic          we1, bz1, dn1, we0, bz0, dn0;
  logic [AW-1:0] wa1, wa0;
  logic [11:0]   wd1, wd0;

  int chk = 0;
  int err = 0;

  function automatic logic [23:0] pix(int hh, int vv, int p);
    if (p == 0) return {8'(vv), 8'(hh), 8'hA5};
    return {8'(vv * 64 + 31), 8'(hh * 32 + 12), 8'(240 - hh * 16)};
  endfunction

  assign rgb1 = pix(int'(ph), int'(pv), pat);
  assign rgb0 = pix(int'(h), int'(v), pat);

  photo_capture #(
    .PIPE_DLY(1), .WIN_X(WX), .WIN_Y(WY),
    .WIN_W(WW), .WIN_H(WH), .ADDR_W(AW)
  ) dut1 (
    .clk(clk), .rst(rst), .capture(cap1), .abort(abt1),
    .hcount(h), .vcount(v), .rgb_in(rgb1),
    .wr_en(we1), .wr_addr(wa1), .wr_data(wd1),
    .busy(bz1), .done(dn1)
  );

  photo_capture #(
    .PIPE_DLY(0), .WIN_X(WX), .WIN_Y(WY),
    .WIN_W(WW), .WIN_H(WH), .ADDR_W(AW)
  ) dut0 (
    .clk(clk), .rst(rst), .capture(cap0), .abort(abt0),
    .hcount(h), .vcount(v), .rgb_in(rgb0),
    .wr_en(we0), .wr_addr(wa0), .wr_data(wd0),
    .busy(bz0), .done(dn0)
  );

  always #5 clk = ~clk;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // reference: armed/active/finishing flags, address from window position
  int m_armed[2], m_act[2], m_fin[2], m_wr[2];
  int e_we[2], e_wa[2], e_wd[2], e_bz[2], e_dn[2];

  task automatic mclear();
    for (int k = 0; k < 2; k++) begin
      m_armed[k] = 0; m_act[k] = 0; m_fin[k] = 0;
      e_we[k] = 0; e_wa[k] = 0; e_wd[k] = 0; e_bz[k] = 0; e_dn[k] = 0;
    end
  endtask

  task automatic mstep(int k, int hd, int vd, logic [23:0] px,
                       logic c, logic a);
    int addr;
    e_we[k] = 0;
    e_dn[k] = 0;
    if (m_fin[k] != 0) begin
      m_fin[k] = 0; e_dn[k] = 1; e_bz[k] = 0;
    end else if ((m_armed[k] != 0 || m_act[k] != 0) && a) begin
      m_armed[k] = 0; m_act[k] = 0; e_bz[k] = 0;
    end else begin
      if (m_armed[k] != 0 && hd == 0 && vd == 0) begin
        m_armed[k] = 0; m_act[k] = 1;
      end else if (m_armed[k] == 0 && m_act[k] == 0 && c) begin
        m_armed[k] = 1; e_bz[k] = 1;
      end
      if (m_act[k] != 0 && hd >= WX && hd < WX + WW &&
          vd >= WY && vd < WY + WH) begin
        addr = (vd - WY) * WW + (hd - WX);
        e_we[k] = 1;
        e_wa[k] = addr;
        e_wd[k] = (int'(px[23:16]) / 16) * 256 +
                  (int'(px[15:8]) / 16) * 16 + int'(px[7:0]) / 16;
        m_wr[k]++;
        if (addr == NPIX - 1) begin
          m_act[k] = 0; m_fin[k] = 1;
        end
      end
    end
  endtask

  initial begin
    mclear();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) mclear();
      else begin
        mstep(1, int'(ph), int'(pv), rgb1, cap1, abt1);
        mstep(0, int'(h), int'(v), rgb0, cap0, abt0);
      end
    end
  end

  int s_wr[2], s_dn[2], f_addr[2], f_data[2], f_pos[2], f_frame[2];
  int l_addr[2], l_data[2], l_pos[2], d_pos[2];

  task automatic clear_stats();
    for (int k = 0; k < 2; k++) begin
      s_wr[k] = 0; s_dn[k] = 0; f_addr[k] = -1; f_data[k] = -1;
      f_pos[k] = -1; f_frame[k] = -1; l_addr[k] = -1; l_data[k] = -1;
      l_pos[k] = -1; d_pos[k] = -1; m_wr[k] = 0;
    end
  endtask

  task automatic note(int k, logic w, int a, int d, logic dn);
    if (w) begin
      if (s_wr[k] == 0) begin
        f_addr[k] = a; f_data[k] = d;
        f_pos[k] = r % FR; f_frame[k] = r / FR;
      end
      s_wr[k]++;
      l_addr[k] = a; l_data[k] = d; l_pos[k] = r % FR;
    end
    if (dn) begin
      s_dn[k]++;
      d_pos[k] = r % FR;
    end
  endtask

  initial begin
    clear_stats();
    forever begin
      @(negedge clk);
      check("wr_en1", 32'(we1), e_we[1]);
      check("wr_addr1", 32'(wa1), e_wa[1]);
      check("wr_data1", 32'(wd1), e_wd[1]);
      check("busy1", 32'(bz1), e_bz[1]);
      check("done1", 32'(dn1), e_dn[1]);
      check("wr_en0", 32'(we0), e_we[0]);
      check("wr_addr0", 32'(wa0), e_wa[0]);
      check("wr_data0", 32'(wd0), e_wd[0]);
      check("busy0", 32'(bz0), e_bz[0]);
      check("done0", 32'(dn0), e_dn[0]);
      note(1, we1, int'(wa1), int'(wd1), dn1);
      note(0, we0, int'(wa0), int'(wd0), dn0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (!rst) begin
      ph = '0; pv = '0;
    end else begin
      ph = h; pv = v;
    end
    r++;
    h = 11'(r % HT);
    v = 10'((r / HT) % VT);
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic goto_pos(int p);
    for (int i = 0; i < FR && (r % FR) != p; i++) step();
  endtask

  task automatic wait_wr(int k, int n, int lim);
    for (int i = 0; i < lim && m_wr[k] < n; i++) step();
    if (m_wr[k] < n) check("wait_wr_timeout", 32'(m_wr[k]), 32'(n));
  endtask

  int cf;

  initial begin
    rst = 1'b0;
    run(3);
    check("rst_wr_en", 32'(we1), 0);
    check("rst_wr_addr", 32'(wa1), 0);
    check("rst_wr_data", 32'(wd1), 0);
    check("rst_busy", 32'(bz1), 0);
    check("rst_done", 32'(dn1), 0);
    rst = 1'b1;
    run(2);

    // basic capture, request mid-frame
    goto_pos(5);
    cf = r / FR;
    clear_stats();
    cap1 = 1'b1; step(); cap1 = 1'b0;
    run(60);
    check("t1_writes", 32'(s_wr[1]), 8);
    check("t1_frame", 32'(f_frame[1]), 32'(cf + 1));
    check("t1_first_addr", 32'(f_addr[1]), 0);
    check("t1_first_data", 32'(f_data[1]), 32'h00A);
    check("t1_first_pos", 32'(f_pos[1]), 12);
    check("t1_last_addr", 32'(l_addr[1]), 7);
    check("t1_last_data", 32'(l_data[1]), 32'h00A);
    check("t1_last_pos", 32'(l_pos[1]), 23);
    check("t1_dones", 32'(s_dn[1]), 1);
    check("t1_done_pos", 32'(d_pos[1]), 24);
    check("t1_busy_end", 32'(bz1), 0);

    // request coincident with frame start skips that frame
    pat = 1;
    goto_pos(1);
    cf = r / FR;
    clear_stats();
    cap1 = 1'b1; step(); cap1 = 1'b0;
    run(70);
    check("t2_writes", 32'(s_wr[1]), 8);
    check("t2_frame", 32'(f_frame[1]), 32'(cf + 1));
    check("t2_first_data", 32'(f_data[1]), 32'h54D);
    check("t2_last_data", 32'(l_data[1]), 32'h9AA);
    check("t2_dones", 32'(s_dn[1]), 1);

    // abort after third write, then restart
    pat = 0;
    goto_pos(5);
    clear_stats();
    cap1 = 1'b1; step(); cap1 = 1'b0;
    wait_wr(1, 3, 80);
    abt1 = 1'b1; step(); abt1 = 1'b0;
    run(40);
    check("t3_writes", 32'(s_wr[1]), 3);
    check("t3_dones", 32'(s_dn[1]), 0);
    check("t3_busy", 32'(bz1), 0);
    goto_pos(5);
    clear_stats();
    cap1 = 1'b1; step(); cap1 = 1'b0;
    run(60);
    check("t3_re_writes", 32'(s_wr[1]), 8);
    check("t3_re_first", 32'(f_addr[1]), 0);
    check("t3_re_dones", 32'(s_dn[1]), 1);

    // extra requests while busy are ignored
    goto_pos(5);
    clear_stats();
    cap1 = 1'b1; step(); cap1 = 1'b0;
    run(3);
    cap1 = 1'b1; step(); cap1 = 1'b0;
    wait_wr(1, 2, 80);
    cap1 = 1'b1; step(); cap1 = 1'b0;
    run(60);
    check("t4_writes", 32'(s_wr[1]), 8);
    check("t4_dones", 32'(s_dn[1]), 1);

    // asynchronous reset mid-capture
    goto_pos(5);
    clear_stats();
    cap1 = 1'b1; step(); cap1 = 1'b0;
    wait_wr(1, 2, 80);
    #2;
    rst = 1'b0;
    #1;
    check("t5_wr_en", 32'(we1), 0);
    check("t5_wr_addr", 32'(wa1), 0);
    check("t5_wr_data", 32'(wd1), 0);
    check("t5_busy", 32'(bz1), 0);
    check("t5_done", 32'(dn1), 0);
    run(2);
    rst = 1'b1;
    run(60);
    check("t5_writes", 32'(s_wr[1]), 1);
    check("t5_dones", 32'(s_dn[1]), 0);
    check("t5_busy_end", 32'(bz1), 0);

    // zero pipe delay: same writes one cycle earlier
    goto_pos(5);
    clear_stats();
    cap0 = 1'b1; step(); cap0 = 1'b0;
    run(60);
    check("t6_writes", 32'(s_wr[0]), 8);
    check("t6_first_addr", 32'(f_addr[0]), 0);
    check("t6_first_data", 32'(f_data[0]), 32'h00A);
    check("t6_first_pos", 32'(f_pos[0]), 11);
    check("t6_last_addr", 32'(l_addr[0]), 7);
    check("t6_last_data", 32'(l_data[0]), 32'h00A);
    check("t6_last_pos", 32'(l_pos[0]), 22);
    check("t6_done_pos", 32'(d_pos[0]), 23);
    check("t6_dones", 32'(s_dn[0]), 1);

    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

endmodule
